mult_unit: RTL and testbench

Sequential 32x32 multiplier for the MULT/MULTU path of the five-stage MIPS core. It uses a start/busy/done handshake and produces a 64-bit product into HI/LO registers. Where the existing subtractor is single-cycle combinational, this block is the complementary multi-cycle shift-add unit. It sits beside the EX-stage ALU, and hazard logic stalls on `busy`.

---
 rtl/mult_unit.sv | 120 ++++++++++++
 tb/tb_mult_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// Sequential 32x32 shift-add multiplier for MULT/MULTU with a start/busy/done handshake.
// Result is written to HI/LO in FIX. The ALU hazard logic stalls while busy is high.
//
// state  | meaning
// IDLE   | waiting for start; HI/LO/flags hold the last result
// CALC   | one multiplier bit per cycle, LSB first, for 32 cycles
// FIX    | apply the sign to the magnitude product, load HI/LO, pulse done
module mult_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        zero,
    output logic        neg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic        r_sign;
    logic        r_signed;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_zero;
    logic        r_neg;

    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [63:0] w_acc_next;
    logic [63:0] w_product;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    always_comb begin
        w_mag1     = (is_signed && data1[31]) ? (~data1 + 32'd1) : data1;
        w_mag2     = (is_signed && data2[31]) ? (~data2 + 32'd1) : data2;
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_product  = r_sign ? (~r_acc + 64'd1) : r_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_sign   <= 1'b0;
            r_signed <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_zero   <= 1'b1;
            r_neg    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {32'd0, w_mag1};
                        r_mplier <= w_mag2;
                        r_sign   <= is_signed & (data1[31] ^ data2[31]);
                        r_signed <= is_signed;
                        r_acc    <= 64'd0;
                        r_cnt    <= 5'd0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    // a flush arriving in FIX still suppresses the result
                    if (!cancel) begin
                        r_hi   <= w_product[63:32];
                        r_lo   <= w_product[31:0];
                        r_zero <= (w_product == 64'd0);
                        r_neg  <= r_signed & w_product[63];
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign zero = r_zero;
    assign neg  = r_neg;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner cases, handshake/cancel/reset
// scenarios and randomized operands checked against an arithmetic product model.
module tb_mult_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        neg;

    int n_tests = 0;
    int n_fail  = 0;

    mult_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .data1     (data1),
        .data2     (data2),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .zero      (zero),
        .neg       (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return sa * sb;
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Issue one op, expect done exactly 33 edges after the accepting edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic cancel_at_start, input string tag);
        logic [63:0] p;
        int lat;
        p = model(a, b, s);
        @(negedge clk);
        start = 1'b1; data1 = a; data2 = b; is_signed = s; cancel = cancel_at_start;
        @(posedge clk); #1;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        data1 = $urandom; data2 = $urandom; is_signed = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_hi"}, 64'(hi), 64'(p[63:32]));
        check({tag, "_lo"}, 64'(lo), 64'(p[31:0]));
        check({tag, "_zero"}, 64'(zero), 64'(p == 64'd0));
        check({tag, "_neg"}, 64'(neg), 64'(s & p[63]));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int first_done;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; data1 = '0; data2 = '0; cancel = 1'b0;
        #23;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_neg", 64'(neg), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_ones");
        check("multu_ones_hi_const", 64'(hi), 64'hFFFF_FFFE);
        check("multu_ones_lo_const", 64'(lo), 64'h0000_0001);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "mult_ones");
        check("mult_ones_hi_const", 64'(hi), 64'h0);
        run_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0, "mult_mixed");
        check("mult_mixed_lo_const", 64'(lo), 64'hFFFF_FFFA);
        check("mult_mixed_neg_const", 64'(neg), 64'd1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "mult_minmin");
        check("mult_minmin_hi_const", 64'(hi), 64'h4000_0000);
        run_op(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, "mult_zero");
        check("mult_zero_flag_const", 64'(zero), 64'd1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, "start_with_cancel");

        // start pulses during busy are ignored; start held into E34 is accepted
        @(negedge clk);
        start = 1'b1; data1 = 32'd7; data2 = 32'd6; is_signed = 1'b0;
        @(posedge clk); #1;
        check("busy_start_busy", 64'(busy), 64'd1);
        first_done = 0;
        for (int e = 1; e <= 34; e++) begin
            @(negedge clk);
            start = (e == 5 || e == 33 || e == 34);
            data1 = 32'd2; data2 = 32'd2;
            @(posedge clk); #1;
            if (done && first_done == 0) first_done = e;
            if (e == 33) begin
                check("busy_ignore_lo", 64'(lo), 64'd42);
                check("busy_ignore_busy_e33", 64'(busy), 64'd0);
            end
        end
        check("busy_ignore_done_edge", 64'(first_done), 64'd33);
        check("busy_e34_accept", 64'(busy), 64'd1);
        @(negedge clk); start = 1'b0;
        first_done = 0;
        for (int e = 35; e <= 75; e++) begin
            @(posedge clk); #1;
            if (done && first_done == 0) first_done = e;
            if (first_done != 0) break;
        end
        check("e34_done_edge", 64'(first_done), 64'd67);
        check("e34_lo", 64'(lo), 64'd4);

        // cancel during CALC
        run_op(32'd7, 32'd6, 1'b0, 1'b0, "pre_cancel");
        @(negedge clk);
        start = 1'b1; data1 = 32'd5; data2 = 32'd5; is_signed = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        for (int e = 1; e < 20; e++) @(posedge clk);
        @(negedge clk); cancel = 1'b1;
        @(posedge clk); #1;
        check("cancel_busy_e20", 64'(busy), 64'd0);
        @(negedge clk); cancel = 1'b0;
        count_done(40, nd);
        check("cancel_no_done", 64'(nd), 64'd0);
        check("cancel_lo_kept", 64'(lo), 64'd42);

        // cancel in FIX beats the done transition
        @(negedge clk);
        start = 1'b1; data1 = 32'd9; data2 = 32'd9; is_signed = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        for (int e = 1; e < 33; e++) @(posedge clk);
        @(negedge clk); cancel = 1'b1;
        @(posedge clk); #1;
        check("cancel_fix_done", 64'(done), 64'd0);
        check("cancel_fix_busy", 64'(busy), 64'd0);
        @(negedge clk); cancel = 1'b0;
        count_done(40, nd);
        check("cancel_fix_no_done", 64'(nd), 64'd0);
        check("cancel_fix_lo_kept", 64'(lo), 64'd42);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            if (i % 7 == 0) ra = 32'h8000_0000;
            if (i % 11 == 0) rb = 32'hFFFF_FFFF;
            run_op(ra, rb, rs, 1'($urandom_range(0, 3) == 0), "rand");
        end

        // asynchronous reset mid-CALC
        @(negedge clk);
        start = 1'b1; data1 = 32'd3; data2 = 32'd3; is_signed = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        for (int e = 1; e <= 10; e++) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_zero", 64'(zero), 64'd1);
        check("arst_neg", 64'(neg), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        count_done(40, nd);
        check("arst_no_done", 64'(nd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
